// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and state encoding for the UART command-frame parser.
package uart_frame_parser_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_PLAY  = 8'h02;
    localparam logic [7:0] CMD_STOP  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK
    } parser_state_t;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_PLAY) || (cmd == CMD_STOP);
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-strobe input side and command/status output side of the frame parser.
interface uart_frame_parser_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  i_RX_DV;
    logic [7:0]            i_RX_Byte;
    logic                  o_Wr_En;
    logic [ADDR_WIDTH-1:0] o_Wr_Addr;
    logic [7:0]            o_Wr_Data;
    logic                  o_Play_Start;
    logic                  o_Play_Stop;
    logic                  o_Frame_Err;
    logic [7:0]            o_Err_Count;
    logic                  o_Busy;

    modport master (
        output i_RX_DV,
        output i_RX_Byte,
        input  o_Wr_En,
        input  o_Wr_Addr,
        input  o_Wr_Data,
        input  o_Play_Start,
        input  o_Play_Stop,
        input  o_Frame_Err,
        input  o_Err_Count,
        input  o_Busy
    );

    modport slave (
        input  i_RX_DV,
        input  i_RX_Byte,
        output o_Wr_En,
        output o_Wr_Addr,
        output o_Wr_Data,
        output o_Play_Start,
        output o_Play_Stop,
        output o_Frame_Err,
        output o_Err_Count,
        output o_Busy
    );

endinterface

// File: rtl/uart_frame_parser_frame_timeout.sv
// Clearable up-counter that saturates at TIMEOUT_CLKS and flags expiry while there.
module frame_timeout #(
    parameter int TIMEOUT_CLKS = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    output logic o_Expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CLKS);

    logic [CNT_W-1:0] count;

    // Holding at the limit keeps the expiry flag up until the parser reacts and clears it.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (i_Clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_Expired = (count == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Validates 5-byte SYNC/CMD/ADDR/DATA/CHK frames and turns good ones into BRAM writes or playback pulses.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int TIMEOUT_CLKS = 2_500_000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    uart_frame_parser_if.slave  bus
);

    localparam logic [7:0] ADDR_HI_MASK = 8'hFF << ADDR_WIDTH;

    parser_state_t state;
    parser_state_t state_next;

    logic [7:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] chk_q;

    logic timeout_clear;
    logic timeout_expired;
    logic frame_good;

    logic wr_next;
    logic start_next;
    logic stop_next;
    logic err_next;

    assign timeout_clear = bus.i_RX_DV || (state == S_IDLE);

    frame_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_frame_timeout (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Clear   (timeout_clear),
        .o_Expired (timeout_expired)
    );

    // Only meaningful while the CHK byte is on the bus; chk_q already folds in CMD^ADDR^DATA.
    assign frame_good = (chk_q == bus.i_RX_Byte)
                     && is_known_cmd(cmd_q)
                     && !((cmd_q == CMD_WRITE) && ((addr_q & ADDR_HI_MASK) != 8'h00));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte strobe always takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        start_next = 1'b0;
        stop_next  = 1'b0;
        err_next   = 1'b0;

        if (bus.i_RX_DV) begin
            case (state)
                S_IDLE: begin
                    if (bus.i_RX_Byte == SYNC_BYTE) begin
                        state_next = S_CMD;
                    end
                end
                S_CMD:  state_next = S_ADDR;
                S_ADDR: state_next = S_DATA;
                S_DATA: state_next = S_CHK;
                S_CHK: begin
                    state_next = S_IDLE;
                    if (frame_good) begin
                        case (cmd_q)
                            CMD_WRITE: wr_next    = 1'b1;
                            CMD_PLAY:  start_next = 1'b1;
                            CMD_STOP:  stop_next  = 1'b1;
                            default:   err_next   = 1'b1;
                        endcase
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (timeout_expired && (state != S_IDLE)) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cmd_q  <= 8'h00;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            chk_q  <= 8'h00;
        end else if (bus.i_RX_DV) begin
            case (state)
                S_CMD: begin
                    cmd_q <= bus.i_RX_Byte;
                    chk_q <= bus.i_RX_Byte;
                end
                S_ADDR: begin
                    addr_q <= bus.i_RX_Byte;
                    chk_q  <= chk_q ^ bus.i_RX_Byte;
                end
                S_DATA: begin
                    data_q <= bus.i_RX_Byte;
                    chk_q  <= chk_q ^ bus.i_RX_Byte;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bus.o_Wr_En      <= 1'b0;
            bus.o_Wr_Addr    <= '0;
            bus.o_Wr_Data    <= 8'h00;
            bus.o_Play_Start <= 1'b0;
            bus.o_Play_Stop  <= 1'b0;
            bus.o_Frame_Err  <= 1'b0;
            bus.o_Err_Count  <= 8'h00;
            bus.o_Busy       <= 1'b0;
        end else begin
            bus.o_Wr_En      <= wr_next;
            bus.o_Play_Start <= start_next;
            bus.o_Play_Stop  <= stop_next;
            bus.o_Frame_Err  <= err_next;
            bus.o_Busy       <= (state_next != S_IDLE);
            if (wr_next) begin
                bus.o_Wr_Addr <= addr_q[ADDR_WIDTH-1:0];
                bus.o_Wr_Data <= data_q;
            end
            if (err_next && (bus.o_Err_Count != 8'hFF)) begin
                bus.o_Err_Count <= bus.o_Err_Count + 8'd1;
            end
        end
    end

endmodule
